// File: rtl/spart_pkg.sv
// Shared register map, FSM state encodings and baud divisor presets for the SPART.
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_BUF    = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DIV_LO = 2'b10,
    ADDR_DIV_HI = 2'b11
  } reg_addr_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Divisors for 16x oversampling from a 50 MHz clock.
  localparam logic [15:0] DIV_4800  = 16'd650;
  localparam logic [15:0] DIV_9600  = 16'd324;
  localparam logic [15:0] DIV_19200 = 16'd161;
  localparam logic [15:0] DIV_38400 = 16'd80;

  localparam logic [3:0] TICK_MID  = 4'd7;
  localparam logic [3:0] TICK_LAST = 4'd15;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: down-counter that pulses tick_o for one cycle at zero,
// giving one tick every divisor+1 clocks; load_i restarts it from the new divisor.
module spart_baud_gen #(
  parameter logic [15:0] DFLT_DIV = 16'd161
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor_i,
  input  logic        load_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 16'd1;
    if (load_i || (cnt_q == 16'd0)) begin
      cnt_d = divisor_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= DFLT_DIV;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == 16'd0);

endmodule

// File: rtl/spart.sv
// Minimal UART with a 4-register processor port: 8N1 transmitter and receiver
// clocked by a shared 16x baud tick; reads are combinational, writes take effect at the edge.
module spart
  import spart_pkg::*;
#(
  parameter logic [15:0] DFLT_DIV = DIV_19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  reg_addr_e   addr;
  logic        rd_en, wr_en;
  logic [15:0] div_q, div_d;
  logic        div_load;
  logic        tick;
  logic [7:0]  rd_dat;

  assign addr  = reg_addr_e'(ioaddr);
  assign rd_en = iocs & iorw;
  assign wr_en = iocs & ~iorw;

  always_comb begin
    div_d    = div_q;
    div_load = 1'b0;
    if (wr_en && (addr == ADDR_DIV_LO)) begin
      div_d[7:0] = databus;
      div_load   = 1'b1;
    end
    if (wr_en && (addr == ADDR_DIV_HI)) begin
      div_d[15:8] = databus;
      div_load    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DFLT_DIV;
    end else begin
      div_q <= div_d;
    end
  end

  // The generator sees the post-write divisor so a reload uses the new value at once.
  spart_baud_gen #(.DFLT_DIV(DFLT_DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .divisor_i(div_d),
    .load_i   (div_load),
    .tick_o   (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e  tx_state_q;
  logic [7:0] tx_shift_q;
  logic [3:0] tx_tick_q;
  logic [2:0] tx_bit_q;
  logic       txd_q, tbr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= 8'h00;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      txd_q      <= 1'b1;
      tbr_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (wr_en && (addr == ADDR_BUF)) begin
            tx_shift_q <= databus;
            tx_tick_q  <= 4'd0;
            tx_state_q <= TX_START;
            txd_q      <= 1'b0;
            tbr_q      <= 1'b0;
          end
        end
        TX_START: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == TICK_LAST) begin
              tx_state_q <= TX_DATA;
              tx_bit_q   <= 3'd0;
              txd_q      <= tx_shift_q[0];
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == TICK_LAST) begin
              if (tx_bit_q == 3'd7) begin
                tx_state_q <= TX_STOP;
                txd_q      <= 1'b1;
              end else begin
                tx_bit_q   <= tx_bit_q + 3'd1;
                tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                txd_q      <= tx_shift_q[1];
              end
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == TICK_LAST) begin
              tx_state_q <= TX_IDLE;
              tbr_q      <= 1'b1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic [1:0] sync_q;
  logic       rx_s, rx_prev_q;
  rx_state_e  rx_state_q;
  logic [7:0] rx_shift_q, rx_buf_q;
  logic [3:0] rx_tick_q;
  logic [2:0] rx_bit_q;
  logic       rda_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_prev_q  <= 1'b1;
      rx_shift_q <= 8'h00;
      rx_buf_q   <= 8'h00;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rda_q      <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      // A buffer read clears rda unless a byte lands this cycle; the set below wins.
      if (rd_en && (addr == ADDR_BUF)) begin
        rda_q <= 1'b0;
      end
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            rx_state_q <= RX_START;
            rx_tick_q  <= 4'd0;
          end
        end
        RX_START: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if ((rx_tick_q == TICK_MID) && rx_s) begin
              rx_state_q <= RX_IDLE;
            end else if (rx_tick_q == TICK_LAST) begin
              rx_state_q <= RX_DATA;
              rx_bit_q   <= 3'd0;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == TICK_MID) begin
              rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            end
            if (rx_tick_q == TICK_LAST) begin
              if (rx_bit_q == 3'd7) begin
                rx_state_q <= RX_STOP;
              end else begin
                rx_bit_q <= rx_bit_q + 3'd1;
              end
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == TICK_MID) begin
              if (rx_s) begin
                rx_buf_q <= rx_shift_q;
                rda_q    <= 1'b1;
              end
              rx_state_q <= RX_IDLE;
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- processor read port ----------------
  always_comb begin
    case (addr)
      ADDR_BUF:    rd_dat = rx_buf_q;
      ADDR_STATUS: rd_dat = {6'b0, tbr_q, rda_q};
      ADDR_DIV_LO: rd_dat = div_q[7:0];
      default:     rd_dat = div_q[15:8];
    endcase
  end

  assign databus = rd_en ? rd_dat : 8'hzz;
  assign rda     = rda_q;
  assign tbr     = tbr_q;
  assign txd     = txd_q;

endmodule

// File: tb/tb_spart.sv
// Bench for spart: randomized UART traffic checked against a bit-timing model;
// transmitted bytes are scoreboarded and decoded off txd by an independent monitor.
module tb_spart;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b1;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic [7:0] tb_dat = 8'h00;
  logic       tb_drv = 1'b0;
  wire  [7:0] databus;
  logic       rda, tbr, txd;

  assign databus = tb_drv ? tb_dat : 8'hzz;

  spart #(.DFLT_DIV(16'd161)) dut (
    .clk    (clk),
    .rst    (rst),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .databus(databus),
    .rda    (rda),
    .tbr    (tbr),
    .txd    (txd),
    .rxd    (rxd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int cur_div = 161;
  int rst_count = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] exp_buf = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dat = d; tb_drv = 1'b1;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0;
  endtask

  task automatic set_div(input int d);
    logic [15:0] dv;
    dv = 16'(d);
    bus_write(2'b10, dv[7:0]);
    bus_write(2'b11, dv[15:8]);
    cur_div = d;
  endtask

  // Drive one serial frame on rxd at the current bit period.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    int bp;
    logic [9:0] fr;
    bp = 16 * (cur_div + 1);
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (bp) @(negedge clk);
    end
    rxd = 1'b1;
    if (stop_bit) exp_buf = b;
  endtask

  task automatic wait_tbr(input string name, input int budget);
    int g;
    g = 0;
    while (tbr !== 1'b1 && g < budget) begin
      @(negedge clk);
      g++;
    end
    check(name, tbr, 1'b1);
  endtask

  // Edge timing of a frame just started: every level change must sit on a
  // bit boundary of the ideal frame, and tbr returns at the end of the stop bit.
  task automatic measure_tx(input logic [7:0] b);
    logic [9:0] fr;
    int bp, g, n;
    int bnd[$];
    int t[$];
    logic last;
    fr = {1'b1, b, 1'b0};
    bp = 16 * (cur_div + 1);
    for (int i = 1; i < 10; i++) if (fr[i] != fr[i-1]) bnd.push_back(i);
    n = bnd.size();
    last = 1'b1;
    g = 0;
    while (t.size() < n + 1 && g < 12 * bp) begin
      if (txd !== last) begin
        t.push_back(cyc);
        last = txd;
      end
      @(negedge clk);
      g++;
    end
    check("tx_edge_count", t.size(), n + 1);
    if (t.size() == n + 1) begin
      check("tx_start_len_in_window",
            ((t[1] - t[0]) >= (bnd[0] * bp - cur_div)) && ((t[1] - t[0]) <= bnd[0] * bp), 1'b1);
      for (int k = 1; k < n; k++)
        check("tx_edge_spacing", t[k+1] - t[k], (bnd[k] - bnd[k-1]) * bp);
      g = 0;
      while (tbr !== 1'b1 && g < 3 * bp) begin
        @(negedge clk);
        g++;
      end
      check("tbr_after_stop", cyc - t[n], (10 - bnd[n-1]) * bp);
    end
  endtask

  // Independent txd decoder: samples each bit near its centre and scoreboards.
  initial begin : tx_monitor
    int rs, d, bp, first;
    logic [7:0] b;
    logic stp;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        rs = rst_count;
        d = cur_div;
        bp = 16 * (d + 1);
        first = bp - d / 2 + bp / 2;
        repeat (first) @(negedge clk);
        b[0] = txd;
        for (int k = 1; k < 8; k++) begin
          repeat (bp) @(negedge clk);
          b[k] = txd;
        end
        repeat (bp) @(negedge clk);
        stp = txd;
        if (rs == rst_count) begin
          if (tx_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected_frame: got byte %02h, required no frame", b);
          end else begin
            check("tx_byte", b, tx_exp.pop_front());
            check("tx_stop_bit", stp, 1'b1);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] rd;
    logic [7:0] tb_byte, rb, rb2;
    int bp, g;
    int tk[$];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_txd", txd, 1'b1);
    check("reset_tbr", tbr, 1'b1);
    check("reset_rda", rda, 1'b0);
    bus_read(2'b01, rd); check("reset_status", rd, 8'h02);
    bus_read(2'b10, rd); check("reset_div_lo", rd, 8'hA1);
    bus_read(2'b11, rd); check("reset_div_hi", rd, 8'h00);
    bus_read(2'b00, rd); check("reset_rx_buf", rd, 8'h00);

    // Baud tick spacing with divisor 80.
    set_div(80);
    bus_read(2'b10, rd); check("div_lo_readback", rd, 8'h50);
    g = 0;
    while (tk.size() < 3 && g < 1000) begin
      @(negedge clk);
      g++;
      if (dut.u_baud.tick_o === 1'b1) tk.push_back(cyc);
    end
    check("tick_count", tk.size(), 3);
    if (tk.size() == 3) begin
      check("tick_spacing_a", tk[1] - tk[0], 81);
      check("tick_spacing_b", tk[2] - tk[1], 81);
    end

    // Full-rate TX of A5 alongside an RX frame of 3C.
    tx_exp.push_back(8'hA5);
    bus_write(2'b00, 8'hA5);
    check("tbr_low_after_write", tbr, 1'b0);
    fork
      measure_tx(8'hA5);
      begin
        repeat (5) @(negedge clk);
        send_rx(8'h3C, 1'b1);
      end
    join
    check("rda_after_frame", rda, 1'b1);
    bus_read(2'b00, rd); check("rx_byte_3c", rd, exp_buf);
    check("rda_clear_after_read", rda, 1'b0);

    // Short start glitch, then a framing error: neither may touch rda or the buffer.
    set_div(5);
    bp = 16 * 6;
    rxd = 1'b0;
    repeat (4 * 6) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * bp) @(negedge clk);
    check("rda_after_glitch", rda, 1'b0);
    send_rx(8'($urandom), 1'b0);
    repeat (2 * bp) @(negedge clk);
    check("rda_after_framing_err", rda, 1'b0);
    bus_read(2'b00, rd); check("rx_buf_after_framing_err", rd, exp_buf);

    // Write while busy must be dropped.
    set_div(4);
    bp = 16 * 5;
    tb_byte = 8'($urandom);
    tx_exp.push_back(tb_byte);
    bus_write(2'b00, tb_byte);
    repeat (3 * bp) @(negedge clk);
    bus_write(2'b00, ~tb_byte);
    check("tbr_still_busy", tbr, 1'b0);
    wait_tbr("tbr_busy_frame_done", 12 * bp);
    repeat (12 * bp) @(negedge clk);
    check("txd_idle_after_drop", txd, 1'b1);

    // Randomized traffic at assorted divisors, TX and RX overlapping.
    for (int it = 0; it < 6; it++) begin
      set_div($urandom_range(3, 9));
      tb_byte = 8'($urandom);
      rb = 8'($urandom);
      tx_exp.push_back(tb_byte);
      bus_write(2'b00, tb_byte);
      send_rx(rb, 1'b1);
      check("rand_rda", rda, 1'b1);
      bus_read(2'b00, rd); check("rand_rx_byte", rd, exp_buf);
      check("rand_rda_clear", rda, 1'b0);
      wait_tbr("rand_tbr", 4 * 16 * (cur_div + 1));
    end

    // Overrun: the newest byte replaces the unread one.
    set_div(3);
    rb = 8'($urandom);
    rb2 = 8'($urandom);
    send_rx(rb, 1'b1);
    check("overrun_rda_first", rda, 1'b1);
    send_rx(rb2, 1'b1);
    check("overrun_rda_second", rda, 1'b1);
    bus_read(2'b00, rd); check("overrun_byte", rd, exp_buf);

    // Reset in the middle of a transmission.
    set_div(4);
    bp = 16 * 5;
    bus_write(2'b00, 8'($urandom));
    repeat (4 * bp) @(negedge clk);
    rst_count++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_div = 161;
    exp_buf = 8'h00;
    check("midreset_txd", txd, 1'b1);
    check("midreset_tbr", tbr, 1'b1);
    check("midreset_rda", rda, 1'b0);
    bus_read(2'b10, rd); check("midreset_div_lo", rd, 8'hA1);
    repeat (12 * bp) @(negedge clk);
    check("midreset_txd_quiet", txd, 1'b1);

    check("tx_queue_drained", tx_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
